mitm_control: RTL and testbench
===============================

Name: mitm_control

Overview:
- SPI man-in-the-middle between an SPI master and an SPI slave.
- Forwards SS, SCLK, MOSI (master to slave) and MISO (slave to master) through the sys_clk domain with a fixed latency.
- Decodes each 20-bit frame: 3-bit opcode, 9-bit address, 8-bit data, MSB first.
- Overrides the data field of reads and writes that target one configured address; every other bit passes through unchanged.

Parameters:
- TARGET_ADDR, 9'h09A, address whose transactions are tampered with.
- FAKE_READ_DATA, 8'h5A, byte substituted on miso_out for reads of TARGET_ADDR.
- FAKE_WRITE_DATA, 8'hFF, byte substituted on mosi_out for writes to TARGET_ADDR.
- OP_READ, 3'b110, read opcode.
- OP_WRITE, 3'b101, write opcode.

Ports:
- sys_clk  input  1  system clock, 12 MHz nominal; must be at least 20x the SCLK rate.
- rst  input  1  asynchronous, active-low reset.
- miso_in  input  1  MISO from slave.
- mosi_in  input  1  MOSI from master.
- sclk_in  input  1  SCLK from master; idle low, data sampled on rising edge.
- ss_in  input  1  slave select from master; active-high, high for the whole frame.
- miso_out  output  1  MISO toward master.
- mosi_out  output  1  MOSI toward slave.
- sclk_out  output  1  SCLK toward slave.
- ss_out  output  1  SS toward slave.

Behaviour:
- Reset (rst low, asynchronous): all synchronizer, counter, header and output registers clear to 0; all outputs 0.
- Input path: each input passes through a 2-FF synchronizer. All outputs are registered.
- Latency: every output equals its input delayed by exactly 3 sys_clk cycles, identical for all four signals, so relative edge timing is preserved.
- Edge detection: from the synchronized signals, one cycle after synchronization.
- Frame start: a rising edge of synced SS clears bit_cnt (5-bit), clears header and sets frame_active.
- frame_active is cleared by a falling edge of synced SS or by reset.
- Bit counting:
  - Each synced SCLK rising edge while frame_active shifts the synced MOSI bit into header (12 bits) while bit_cnt<12.
  - It then increments bit_cnt, saturating at 20.
  - bit_cnt = n means frame bit n (0 = MSB) is currently presented on the lines.
- Decode at bit_cnt = 12: op = header[11:9], addr = header[8:0].
  - hit_read = (op==OP_READ && addr==TARGET_ADDR).
  - hit_write = (op==OP_WRITE && addr==TARGET_ADDR).
  - Both flags are held until the frame ends.
- Substitution window: while frame_active and 12 <= bit_cnt <= 19.
  - If hit_read: miso_out = FAKE_READ_DATA[19-bit_cnt] instead of the synced MISO.
  - If hit_write: mosi_out = FAKE_WRITE_DATA[19-bit_cnt] instead of the synced MOSI.
  - The substituted bit uses the same output register as the pass-through path, so it has the same latency alignment.
- Outside the window (bits 0..11, bit_cnt = 20, SS low, non-matching frames): pure pass-through. sclk_out and ss_out are never modified.
- Frames longer than 20 bits: extra bits pass through unmodified.
- Frames shorter than 20 bits: SS fall aborts the frame; substitution stops immediately (pass-through resumes at that cycle); flags clear.
- Opcodes other than OP_READ/OP_WRITE: pass-through.
- Reset mid-frame: outputs go to 0 at once. After release, frame_active stays 0 until the next SS rising edge, so the interrupted frame is forwarded unmodified.
- SS rising while a frame is active (glitch): treated as a new frame start; counters clear.
- Simultaneous SCLK edge and SS fall in the same cycle: SS fall wins; no increment.

Test Plan:
1. Hold rst low, toggle inputs -> all four outputs stay 0. Release rst, ss_in=1 -> ss_out=1 exactly 3 sys_clk cycles later.
2. Read of TARGET_ADDR: mosi frame {110, 9'h09A, 8'h00}, slave returns 8'hA3 in the last 8 bits, SCLK period 20 sys_clk -> mosi_out bit-identical to input (3-cycle delay); miso_out data field = 8'h5A; miso_out bits 0..11 unchanged (0).
3. Read of another address: mosi {110, 9'h120, 8'h00}, miso data 8'hB5 -> miso_out carries 8'hB5 unmodified; all outputs equal inputs delayed 3 cycles.
4. Write to non-target: mosi {101, 9'h037, 8'h6D} -> mosi_out carries 8'h6D. Write to target: mosi {101, 9'h09A, 8'h6D} -> mosi_out data field = 8'hFF.
5. Short frame: read of 9'h09A with ss_in dropped after 15 bits -> substitution stops at the SS fall. The next frame, a read of 9'h120, passes through unmodified.
6. Assert rst during bit 14 of a target read -> outputs 0 immediately. After release the remainder of that frame passes through unmodified. The following target read is tampered again (8'h5A).

Source files
------------

// File: rtl/mitm_control.sv
// ---------------------------------------------------------------------------
// mitm_control
//
// SPI man-in-the-middle. The block sits between an SPI master and an SPI
// slave and forwards all four SPI lines through the sys_clk domain with a
// fixed three-cycle latency (two synchronizer flops plus one output flop).
// While forwarding, it decodes each 20-bit frame (3-bit opcode, 9-bit
// address, 8-bit data, MSB first). Reads of TARGET_ADDR get their data field
// replaced on MISO, and writes to TARGET_ADDR get their data field replaced
// on MOSI. Every other bit, and SCLK/SS at all times, pass through unchanged.
//
// Ports:
//   sys_clk   in   system clock, at least 20x the SCLK rate
//   rst       in   asynchronous reset, active low
//   miso_in   in   MISO from the slave
//   mosi_in   in   MOSI from the master
//   sclk_in   in   SCLK from the master (idle low, sampled on rising edge)
//   ss_in     in   slave select from the master (active high)
//   miso_out  out  MISO toward the master (possibly tampered)
//   mosi_out  out  MOSI toward the slave (possibly tampered)
//   sclk_out  out  SCLK toward the slave
//   ss_out    out  SS toward the slave
// ---------------------------------------------------------------------------
module mitm_control #(
  parameter logic [8:0] TARGET_ADDR     = 9'h09A,
  parameter logic [7:0] FAKE_READ_DATA  = 8'h5A,
  parameter logic [7:0] FAKE_WRITE_DATA = 8'hFF,
  parameter logic [2:0] OP_READ         = 3'b110,
  parameter logic [2:0] OP_WRITE        = 3'b101
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic miso_in,
  input  logic mosi_in,
  input  logic sclk_in,
  input  logic ss_in,
  output logic miso_out,
  output logic mosi_out,
  output logic sclk_out,
  output logic ss_out
);

  // Synchronizer stages, packed as {ss, sclk, mosi, miso}.
  logic [3:0] in_meta;
  logic [3:0] in_sync;

  logic ss_s;
  logic sclk_s;
  logic mosi_s;
  logic miso_s;

  // Edge detection state.
  logic [1:0] prime_cnt;
  logic       ss_prev;
  logic       sclk_prev;
  logic       primed;
  logic       ss_rise;
  logic       ss_fall;
  logic       sclk_rise;

  // Frame tracking state.
  logic        frame_active;
  logic [4:0]  bit_cnt;
  logic [11:0] header;
  logic        hit_read;
  logic        hit_write;
  logic        dec_read;
  logic        dec_write;

  // Output path.
  logic       window;
  logic [2:0] fake_idx;
  logic       miso_next;
  logic       mosi_next;

  assign ss_s   = in_sync[3];
  assign sclk_s = in_sync[2];
  assign mosi_s = in_sync[1];
  assign miso_s = in_sync[0];

  // Two-flop synchronizer for all four inputs.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      in_meta <= '0;
      in_sync <= '0;
    end else begin
      in_meta <= {ss_in, sclk_in, mosi_in, miso_in};
      in_sync <= in_meta;
    end
  end

  // Previous-value registers for edge detection. prime_cnt counts the three
  // cycles after reset during which the synchronizer and the previous-value
  // registers still hold flushed zeros; edges seen then are artefacts of the
  // reset (e.g. SS already high mid-frame), not real transitions.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      prime_cnt <= 2'd0;
      ss_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      if (prime_cnt != 2'd3) begin
        prime_cnt <= prime_cnt + 2'd1;
      end
      ss_prev   <= ss_s;
      sclk_prev <= sclk_s;
    end
  end

  assign primed    = (prime_cnt == 2'd3);
  assign ss_rise   = primed &  ss_s   & ~ss_prev;
  assign ss_fall   = primed & ~ss_s   &  ss_prev;
  assign sclk_rise = primed &  sclk_s & ~sclk_prev;

  assign dec_read  = (header[11:9] == OP_READ)  && (header[8:0] == TARGET_ADDR);
  assign dec_write = (header[11:9] == OP_WRITE) && (header[8:0] == TARGET_ADDR);

  // Frame tracker. SS edges take priority over SCLK edges, so an SS fall in
  // the same cycle as an SCLK rise aborts the frame without counting the bit.
  // The hit flags are latched once the 12-bit header is complete and stay
  // put until the frame ends.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      frame_active <= 1'b0;
      bit_cnt      <= 5'd0;
      header       <= 12'd0;
      hit_read     <= 1'b0;
      hit_write    <= 1'b0;
    end else if (ss_rise) begin
      frame_active <= 1'b1;
      bit_cnt      <= 5'd0;
      header       <= 12'd0;
      hit_read     <= 1'b0;
      hit_write    <= 1'b0;
    end else if (ss_fall) begin
      frame_active <= 1'b0;
      hit_read     <= 1'b0;
      hit_write    <= 1'b0;
    end else if (frame_active) begin
      if (sclk_rise) begin
        if (bit_cnt < 5'd12) begin
          header <= {header[10:0], mosi_s};
        end
        if (bit_cnt < 5'd20) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (bit_cnt == 5'd12) begin
        hit_read  <= dec_read;
        hit_write <= dec_write;
      end
    end
  end

  // Substitution mux. The window closes in the very cycle an SS fall is
  // detected, so a truncated frame goes back to pass-through together with
  // the SS edge on ss_out. Within the window bit_cnt runs 12..19 and the
  // fake-data bit index is 19 - bit_cnt, which over that range equals
  // 3 - bit_cnt[2:0] in 3-bit arithmetic.
  always_comb begin
    window    = frame_active && !ss_fall &&
                (bit_cnt >= 5'd12) && (bit_cnt <= 5'd19);
    fake_idx  = 3'd3 - bit_cnt[2:0];
    miso_next = miso_s;
    mosi_next = mosi_s;
    if (window && hit_read) begin
      miso_next = FAKE_READ_DATA[fake_idx];
    end
    if (window && hit_write) begin
      mosi_next = FAKE_WRITE_DATA[fake_idx];
    end
  end

  // Output register shared by the pass-through and substituted paths, which
  // keeps all four lines on the same three-cycle alignment.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      ss_out   <= 1'b0;
      sclk_out <= 1'b0;
      mosi_out <= 1'b0;
      miso_out <= 1'b0;
    end else begin
      ss_out   <= ss_s;
      sclk_out <= sclk_s;
      mosi_out <= mosi_next;
      miso_out <= miso_next;
    end
  end

endmodule

// File: tb/tb_mitm_control.sv
// ---------------------------------------------------------------------------
// tb_mitm_control
//
// Bench for mitm_control. The bench plays both SPI master and SPI slave.
// For every SCLK rising edge it drives, the expected {mosi, miso} values at
// the matching sclk_out rising edge are pushed to a scoreboard queue; a
// monitor pops and compares them when sclk_out rises. The same monitor also
// checks the three-cycle forwarding of every line against a short input
// history, and that outputs are zero while reset is held.
// ---------------------------------------------------------------------------
module tb_mitm_control;

  localparam int HALF = 10;

  logic sys_clk = 1'b0;
  logic rst     = 1'b0;
  logic miso_in = 1'b0;
  logic mosi_in = 1'b0;
  logic sclk_in = 1'b0;
  logic ss_in   = 1'b0;
  logic miso_out;
  logic mosi_out;
  logic sclk_out;
  logic ss_out;

  int n_checks = 0;
  int n_pass   = 0;

  bit chk_mosi = 1'b0;
  bit chk_miso = 1'b0;

  typedef struct {
    int   n;
    logic em;
    logic es;
  } exp_t;

  exp_t sb[$];

  mitm_control dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .miso_in  (miso_in),
    .mosi_in  (mosi_in),
    .sclk_in  (sclk_in),
    .ss_in    (ss_in),
    .miso_out (miso_out),
    .mosi_out (mosi_out),
    .sclk_out (sclk_out),
    .ss_out   (ss_out)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor: reset-state, latency and scoreboard comparisons at each negedge.
  initial begin
    logic [3:0] hist [3];
    logic       sclk_out_q;
    int         settle;
    exp_t       e;
    hist[0] = '0;
    hist[1] = '0;
    hist[2] = '0;
    sclk_out_q = 1'b0;
    settle = 0;
    forever begin
      @(negedge sys_clk);
      if (!rst) begin
        settle = 0;
        n_checks++;
        if ({ss_out, sclk_out, mosi_out, miso_out} !== 4'b0000) begin
          $display("[TB] FAIL reset_outs: got %b expected 0000",
                   {ss_out, sclk_out, mosi_out, miso_out});
        end else n_pass++;
      end else begin
        if (settle >= 3) begin
          n_checks++;
          if (ss_out !== hist[2][3]) begin
            $display("[TB] FAIL lat_ss at %0t: got %b expected %b", $time, ss_out, hist[2][3]);
          end else n_pass++;
          n_checks++;
          if (sclk_out !== hist[2][2]) begin
            $display("[TB] FAIL lat_sclk at %0t: got %b expected %b", $time, sclk_out, hist[2][2]);
          end else n_pass++;
          if (chk_mosi) begin
            n_checks++;
            if (mosi_out !== hist[2][1]) begin
              $display("[TB] FAIL lat_mosi at %0t: got %b expected %b", $time, mosi_out, hist[2][1]);
            end else n_pass++;
          end
          if (chk_miso) begin
            n_checks++;
            if (miso_out !== hist[2][0]) begin
              $display("[TB] FAIL lat_miso at %0t: got %b expected %b", $time, miso_out, hist[2][0]);
            end else n_pass++;
          end
        end else begin
          settle++;
        end
        if (sclk_out && !sclk_out_q) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL sb_unexpected_edge at %0t: got sclk_out edge expected none", $time);
          end else begin
            e = sb.pop_front();
            n_checks++;
            if (mosi_out !== e.em) begin
              $display("[TB] FAIL sb_mosi bit %0d: got %b expected %b", e.n, mosi_out, e.em);
            end else n_pass++;
            n_checks++;
            if (miso_out !== e.es) begin
              $display("[TB] FAIL sb_miso bit %0d: got %b expected %b", e.n, miso_out, e.es);
            end else n_pass++;
          end
        end
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {ss_in, sclk_in, mosi_in, miso_in};
      sclk_out_q = sclk_out;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Reference model for one frame bit as seen by the far side.
  function automatic exp_t expect_bit(input logic [19:0] mw, input int n, input bit tamper,
                                      input logic m, input logic s);
    exp_t       e;
    logic [7:0] fr;
    logic [7:0] fw;
    bit         hr;
    bit         hw;
    fr = 8'h5A;
    fw = 8'hFF;
    hr = tamper && (mw[19:17] == 3'b110) && (mw[16:8] == 9'h09A);
    hw = tamper && (mw[19:17] == 3'b101) && (mw[16:8] == 9'h09A);
    e.n  = n;
    e.em = m;
    e.es = s;
    if (n >= 12 && n <= 19) begin
      if (hw) e.em = fw[19 - n];
      if (hr) e.es = fr[19 - n];
    end
    return e;
  endfunction

  task automatic send_bit(input logic m, input logic s, input exp_t e);
    mosi_in = m;
    miso_in = s;
    wait_cycles(HALF);
    sclk_in = 1'b1;
    sb.push_back(e);
    wait_cycles(HALF);
    sclk_in = 1'b0;
  endtask

  task automatic send_bits(input logic [19:0] mw, input logic [19:0] sw,
                           input int first, input int last, input bit tamper);
    for (int n = first; n <= last; n++) begin
      logic m;
      logic s;
      if (n < 20) begin
        m = mw[19 - n];
        s = sw[19 - n];
      end else begin
        m = n[0];
        s = ~n[0];
      end
      send_bit(m, s, expect_bit(mw, n, tamper, m, s));
    end
  endtask

  task automatic start_frame();
    wait_cycles(1);
    ss_in = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic end_frame();
    mosi_in = 1'b0;
    miso_in = 1'b0;
    wait_cycles(HALF);
    ss_in = 1'b0;
    wait_cycles(2 * HALF);
  endtask

  task automatic run_frame(input logic [19:0] mw, input logic [19:0] sw,
                           input int nbits, input bit tamper);
    start_frame();
    send_bits(mw, sw, 0, nbits - 1, tamper);
    end_frame();
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    for (int i = 0; i < 8; i++) begin
      wait_cycles(1);
      {ss_in, sclk_in, mosi_in, miso_in} = 4'($urandom);
      #1;
      n_checks++;
      if ({ss_out, sclk_out, mosi_out, miso_out} !== 4'b0000) begin
        $display("[TB] FAIL reset_hold: got %b expected 0000",
                 {ss_out, sclk_out, mosi_out, miso_out});
      end else n_pass++;
    end
    {ss_in, sclk_in, mosi_in, miso_in} = 4'b0000;
    wait_cycles(4);
    rst = 1'b1;
    wait_cycles(6);
    ss_in = 1'b1;
    wait_cycles(2);
    n_checks++;
    if (ss_out !== 1'b0) begin
      $display("[TB] FAIL ss_lat_early: got %b expected 0", ss_out);
    end else n_pass++;
    wait_cycles(1);
    n_checks++;
    if (ss_out !== 1'b1) begin
      $display("[TB] FAIL ss_lat_3: got %b expected 1", ss_out);
    end else n_pass++;
    wait_cycles(HALF);
    ss_in = 1'b0;
    wait_cycles(2 * HALF);
  endtask

  task automatic test_read_target();
    $display("[TB] test_read_target");
    chk_mosi = 1'b1;
    chk_miso = 1'b0;
    run_frame({3'b110, 9'h09A, 8'h00}, {12'h000, 8'hA3}, 20, 1'b1);
    chk_miso = 1'b1;
  endtask

  task automatic test_read_other();
    $display("[TB] test_read_other");
    chk_mosi = 1'b1;
    chk_miso = 1'b1;
    run_frame({3'b110, 9'h120, 8'h00}, {12'h000, 8'hB5}, 20, 1'b1);
  endtask

  task automatic test_write();
    $display("[TB] test_write");
    chk_mosi = 1'b1;
    chk_miso = 1'b1;
    run_frame({3'b101, 9'h037, 8'h6D}, 20'h00000, 20, 1'b1);
    chk_mosi = 1'b0;
    run_frame({3'b101, 9'h09A, 8'h6D}, 20'h00000, 20, 1'b1);
    chk_mosi = 1'b1;
  endtask

  task automatic test_long_frame();
    $display("[TB] test_long_frame");
    chk_mosi = 1'b0;
    chk_miso = 1'b1;
    run_frame({3'b101, 9'h09A, 8'h12}, 20'h00000, 22, 1'b1);
    chk_mosi = 1'b1;
  endtask

  task automatic test_short_frame();
    $display("[TB] test_short_frame");
    chk_mosi = 1'b1;
    chk_miso = 1'b0;
    start_frame();
    send_bits({3'b110, 9'h09A, 8'h00}, {12'h000, 8'hA3}, 0, 14, 1'b1);
    mosi_in = 1'b0;
    miso_in = 1'b0;
    wait_cycles(HALF);
    n_checks++;
    if (miso_out !== 1'b1) begin
      $display("[TB] FAIL short_sub_active: got %b expected 1", miso_out);
    end else n_pass++;
    ss_in = 1'b0;
    wait_cycles(3);
    n_checks++;
    if (miso_out !== 1'b0) begin
      $display("[TB] FAIL short_sub_stop: got %b expected 0", miso_out);
    end else n_pass++;
    wait_cycles(2 * HALF);
    chk_miso = 1'b1;
    run_frame({3'b110, 9'h120, 8'h00}, {12'h000, 8'hB5}, 20, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    logic [19:0] mw;
    logic [19:0] sw;
    logic        m;
    logic        s;
    $display("[TB] test_reset_mid_frame");
    mw = {3'b110, 9'h09A, 8'h00};
    sw = {12'h000, 8'hA3};
    chk_mosi = 1'b1;
    chk_miso = 1'b0;
    start_frame();
    send_bits(mw, sw, 0, 13, 1'b1);
    m = mw[5];
    s = sw[5];
    mosi_in = m;
    miso_in = s;
    wait_cycles(3);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({ss_out, sclk_out, mosi_out, miso_out} !== 4'b0000) begin
      $display("[TB] FAIL rst_mid_outs: got %b expected 0000",
               {ss_out, sclk_out, mosi_out, miso_out});
    end else n_pass++;
    wait_cycles(4);
    rst = 1'b1;
    chk_miso = 1'b1;
    wait_cycles(HALF - 7);
    sclk_in = 1'b1;
    sb.push_back(expect_bit(mw, 14, 1'b0, m, s));
    wait_cycles(HALF);
    sclk_in = 1'b0;
    send_bits(mw, sw, 15, 19, 1'b0);
    end_frame();
    chk_miso = 1'b0;
    run_frame(mw, sw, 20, 1'b1);
    chk_miso = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read_target();
    test_read_other();
    test_write();
    test_long_frame();
    test_short_frame();
    test_reset_mid_frame();
    wait_cycles(10);
    n_checks++;
    if (sb.size() != 0) begin
      $display("[TB] FAIL sb_drain: got %0d pending expected 0", sb.size());
    end else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
